// File: rtl/bwt_arb_pkg.sv
// Shared types and default sizes for the BWT occurrence-memory request arbiter.
package bwt_arb_pkg;

  localparam int unsigned DEF_ADDR_W    = 42;
  localparam int unsigned TAG_RN_W      = 8;
  localparam int unsigned DEF_MAX_OUTST = 16;

  typedef enum logic {
    SRC_FWD = 1'b0,
    SRC_BWD = 1'b1
  } src_e;

  typedef struct packed {
    src_e                read_src;
    logic [TAG_RN_W-1:0] read_num;
  } tag_t;

  // Round-robin successor of a source.
  function automatic src_e other_src(input src_e s);
    return (s == SRC_FWD) ? SRC_BWD : SRC_FWD;
  endfunction

endpackage

// File: rtl/bwt_req_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each in-flight memory read.
module bwt_req_tag_fifo
  import bwt_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_OUTST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  tag_t                   push_tag,
  input  logic                   pop,
  output tag_t                   head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  tag_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_tag;
    end
  end

endmodule

// File: rtl/bwt_req_arbiter.sv
// Round-robin arbiter sharing the BWT occurrence-memory request port between the
// forward and backward datapaths, with in-order response routing.
// Optional: define ARB_PERF_CNT_EN to build the grant/stall performance counters.
module bwt_req_arbiter
  import bwt_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RN_W      = TAG_RN_W,
  parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fwd_req_valid,
  input  logic [RN_W-1:0]            fwd_req_read_num,
  input  logic [ADDR_W-1:0]          fwd_req_addr_k,
  input  logic [ADDR_W-1:0]          fwd_req_addr_l,
  output logic                       fwd_stall,
  input  logic                       bwd_req_valid,
  input  logic [RN_W-1:0]            bwd_req_read_num,
  input  logic [ADDR_W-1:0]          bwd_req_addr_k,
  input  logic [ADDR_W-1:0]          bwd_req_addr_l,
  output logic                       bwd_stall,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_W-1:0]          mem_req_addr_k,
  output logic [ADDR_W-1:0]          mem_req_addr_l,
  output logic [RN_W-1:0]            mem_req_read_num,
  input  logic                       mem_rsp_valid,
  output logic                       fwd_rsp_valid,
  output logic                       bwd_rsp_valid,
  output logic [RN_W-1:0]            rsp_read_num,
  output logic [$clog2(MAX_OUTST):0] outstanding,
  output logic                       rsp_err,
  output logic [31:0]                perf_fwd_grants,
  output logic [31:0]                perf_bwd_grants,
  output logic [31:0]                perf_stall_cycles
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

  logic              hold_f_full_q, hold_f_full_d;
  logic [RN_W-1:0]   hold_f_rn_q, hold_f_rn_d;
  logic [ADDR_W-1:0] hold_f_k_q, hold_f_k_d, hold_f_l_q, hold_f_l_d;
  logic              hold_b_full_q, hold_b_full_d;
  logic [RN_W-1:0]   hold_b_rn_q, hold_b_rn_d;
  logic [ADDR_W-1:0] hold_b_k_q, hold_b_k_d, hold_b_l_q, hold_b_l_d;

  src_e              rr_q, rr_d, grant_q, grant_d, grant;
  logic              lock_q, lock_d;
  logic              rsp_err_q, rsp_err_d;
  logic              fire, issue_f, issue_b, cap_f, cap_b;

  tag_t              push_tag, head_tag;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // Grant selection: hold the previous owner while a request is waiting on ready.
  always_comb begin
    grant = grant_q;
    if (!lock_q) begin
      if (hold_f_full_q && hold_b_full_q) begin
        grant = rr_q;
      end else if (hold_b_full_q) begin
        grant = SRC_BWD;
      end else begin
        grant = SRC_FWD;
      end
    end
  end

  assign mem_req_valid = (hold_f_full_q || hold_b_full_q) && !fifo_full;
  assign fire          = mem_req_valid && mem_req_ready;
  assign issue_f       = fire && (grant == SRC_FWD);
  assign issue_b       = fire && (grant == SRC_BWD);
  assign fwd_stall     = hold_f_full_q && !issue_f;
  assign bwd_stall     = hold_b_full_q && !issue_b;
  assign cap_f         = fwd_req_valid && !fwd_stall;
  assign cap_b         = bwd_req_valid && !bwd_stall;

  // Issued payload comes from the granted hold.
  always_comb begin
    mem_req_addr_k   = hold_f_k_q;
    mem_req_addr_l   = hold_f_l_q;
    mem_req_read_num = hold_f_rn_q;
    if (grant == SRC_BWD) begin
      mem_req_addr_k   = hold_b_k_q;
      mem_req_addr_l   = hold_b_l_q;
      mem_req_read_num = hold_b_rn_q;
    end
    push_tag.read_src = grant;
    push_tag.read_num = TAG_RN_W'(mem_req_read_num);
  end

  // Next state for the skid holds, grant lock, round-robin pointer and error flag.
  always_comb begin
    hold_f_full_d = hold_f_full_q;
    hold_f_rn_d   = hold_f_rn_q;
    hold_f_k_d    = hold_f_k_q;
    hold_f_l_d    = hold_f_l_q;
    hold_b_full_d = hold_b_full_q;
    hold_b_rn_d   = hold_b_rn_q;
    hold_b_k_d    = hold_b_k_q;
    hold_b_l_d    = hold_b_l_q;
    if (cap_f) begin
      hold_f_full_d = 1'b1;
      hold_f_rn_d   = fwd_req_read_num;
      hold_f_k_d    = fwd_req_addr_k;
      hold_f_l_d    = fwd_req_addr_l;
    end else if (issue_f) begin
      hold_f_full_d = 1'b0;
    end
    if (cap_b) begin
      hold_b_full_d = 1'b1;
      hold_b_rn_d   = bwd_req_read_num;
      hold_b_k_d    = bwd_req_addr_k;
      hold_b_l_d    = bwd_req_addr_l;
    end else if (issue_b) begin
      hold_b_full_d = 1'b0;
    end
    lock_d    = mem_req_valid && !mem_req_ready;
    grant_d   = grant;
    rr_d      = fire ? other_src(grant) : rr_q;
    rsp_err_d = rsp_err_q || (mem_rsp_valid && fifo_empty);
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_f_full_q <= 1'b0;
      hold_f_rn_q   <= '0;
      hold_f_k_q    <= '0;
      hold_f_l_q    <= '0;
      hold_b_full_q <= 1'b0;
      hold_b_rn_q   <= '0;
      hold_b_k_q    <= '0;
      hold_b_l_q    <= '0;
      lock_q        <= 1'b0;
      grant_q       <= SRC_FWD;
      rr_q          <= SRC_FWD;
      rsp_err_q     <= 1'b0;
    end else begin
      hold_f_full_q <= hold_f_full_d;
      hold_f_rn_q   <= hold_f_rn_d;
      hold_f_k_q    <= hold_f_k_d;
      hold_f_l_q    <= hold_f_l_d;
      hold_b_full_q <= hold_b_full_d;
      hold_b_rn_q   <= hold_b_rn_d;
      hold_b_k_q    <= hold_b_k_d;
      hold_b_l_q    <= hold_b_l_d;
      lock_q        <= lock_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  bwt_req_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fire),
    .push_tag (push_tag),
    .pop      (mem_rsp_valid),
    .head     (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign fwd_rsp_valid = mem_rsp_valid && !fifo_empty && (head_tag.read_src == SRC_FWD);
  assign bwd_rsp_valid = mem_rsp_valid && !fifo_empty && (head_tag.read_src == SRC_BWD);
  assign rsp_read_num  = fifo_empty ? '0 : RN_W'(head_tag.read_num);
  assign outstanding   = fifo_count;
  assign rsp_err       = rsp_err_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_f_q, perf_f_d, perf_b_q, perf_b_d, perf_s_q, perf_s_d;

  // Grant and stall-cycle counters, free-running with natural wrap.
  always_comb begin
    perf_f_d = perf_f_q + 32'(issue_f);
    perf_b_d = perf_b_q + 32'(issue_b);
    perf_s_d = perf_s_q + 32'(fwd_stall || bwd_stall);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_f_q <= '0;
      perf_b_q <= '0;
      perf_s_q <= '0;
    end else begin
      perf_f_q <= perf_f_d;
      perf_b_q <= perf_b_d;
      perf_s_q <= perf_s_d;
    end
  end

  assign perf_fwd_grants   = perf_f_q;
  assign perf_bwd_grants   = perf_b_q;
  assign perf_stall_cycles = perf_s_q;
`else
  assign perf_fwd_grants   = '0;
  assign perf_bwd_grants   = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule
